// File: rtl/penalty_scoreboard_pkg.sv
// Shared encodings for the penalty shootout scoreboard: FSM states, winner codes
// and the two regulation lengths.
package penalty_scoreboard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_REG    = 2'b01,
        ST_SUDDEN = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_A    = 2'b01;
    localparam logic [1:0] WIN_B    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam int N3 = 3;
    localparam int N5 = 5;

endpackage

// File: rtl/penalty_scoreboard_team_tally.sv
// One team's saturating goal and kick counters. The *_nxt outputs expose the
// post-kick values so the referee can decide on the same edge.
module team_tally #(
    parameter int SCORE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               goal,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] score_nxt,
    output logic [SCORE_W-1:0] kicks_nxt
);

    localparam logic [SCORE_W-1:0] MAX_V = {SCORE_W{1'b1}};

    logic [SCORE_W-1:0] kicks_r;

    // Saturating increment of goals and kicks for an accepted kick by this team
    always_comb begin
        score_nxt = score;
        kicks_nxt = kicks_r;
        if (en) begin
            if (goal && (score != MAX_V)) begin
                score_nxt = score + {{(SCORE_W-1){1'b0}}, 1'b1};
            end else begin
                score_nxt = score;
            end
            if (kicks_r != MAX_V) begin
                kicks_nxt = kicks_r + {{(SCORE_W-1){1'b0}}, 1'b1};
            end else begin
                kicks_nxt = kicks_r;
            end
        end else begin
            score_nxt = score;
            kicks_nxt = kicks_r;
        end
    end

    // Counter registers with async reset and synchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score   <= {SCORE_W{1'b0}};
            kicks_r <= {SCORE_W{1'b0}};
        end else if (clr) begin
            score   <= {SCORE_W{1'b0}};
            kicks_r <= {SCORE_W{1'b0}};
        end else begin
            score   <= score_nxt;
            kicks_r <= kicks_nxt;
        end
    end

endmodule

// File: rtl/penalty_scoreboard.sv
// Penalty shootout referee: alternates shooters, tallies both teams, ends early
// once the result is decided and runs capped sudden death after a tie.
module penalty_scoreboard
    import penalty_scoreboard_pkg::*;
#(
    parameter int SCORE_W = 4,
    parameter int SD_MAX  = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en3p,
    input  logic               en5p,
    input  logic               kick,
    input  logic               goal,
    input  logic               new_game,
    output logic               turn,
    output logic [SCORE_W-1:0] score_a,
    output logic [SCORE_W-1:0] score_b,
    output logic [SCORE_W-1:0] rnd,
    output logic               sudden,
    output logic               done,
    output logic [1:0]         winner
);

    localparam logic [SCORE_W-1:0] MAX_V  = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] SD_LIM = SCORE_W'(SD_MAX);
    localparam logic [SCORE_W-1:0] N3_W   = SCORE_W'(N3);
    localparam logic [SCORE_W-1:0] N5_W   = SCORE_W'(N5);

    state_t             state_r;
    state_t             st_nxt_s;
    logic [SCORE_W-1:0] n_r;
    logic               accept_s;
    logic               en_a_s;
    logic               en_b_s;
    logic [SCORE_W-1:0] sa_nxt_s, sb_nxt_s, ka_nxt_s, kb_nxt_s;
    logic [SCORE_W-1:0] rnd_inc_s, rnd_nxt_s;
    logic [SCORE_W:0]   a_x_s, b_x_s, rem_a_s, rem_b_s;
    logic [1:0]         win_nxt_s;

    assign accept_s = kick & ~new_game & ((state_r == ST_REG) | (state_r == ST_SUDDEN));
    assign en_a_s   = accept_s & ~turn;
    assign en_b_s   = accept_s & turn;

    team_tally #(.SCORE_W(SCORE_W)) u_tally_a (
        .clk(clk), .rst(rst), .clr(new_game), .en(en_a_s), .goal(goal),
        .score(score_a), .score_nxt(sa_nxt_s), .kicks_nxt(ka_nxt_s)
    );

    team_tally #(.SCORE_W(SCORE_W)) u_tally_b (
        .clk(clk), .rst(rst), .clr(new_game), .en(en_b_s), .goal(goal),
        .score(score_b), .score_nxt(sb_nxt_s), .kicks_nxt(kb_nxt_s)
    );

    assign a_x_s   = {1'b0, sa_nxt_s};
    assign b_x_s   = {1'b0, sb_nxt_s};
    assign rem_a_s = {1'b0, n_r} - {1'b0, ka_nxt_s};
    assign rem_b_s = {1'b0, n_r} - {1'b0, kb_nxt_s};

    // Decision on post-kick values; only consumed when a kick is accepted
    always_comb begin
        if (turn && (rnd != MAX_V)) begin
            rnd_inc_s = rnd + {{(SCORE_W-1){1'b0}}, 1'b1};
        end else begin
            rnd_inc_s = rnd;
        end
        st_nxt_s  = state_r;
        rnd_nxt_s = rnd_inc_s;
        win_nxt_s = winner;
        if (state_r == ST_REG) begin
            if (a_x_s > b_x_s + rem_b_s) begin
                st_nxt_s  = ST_DONE;
                win_nxt_s = WIN_A;
            end else if (b_x_s > a_x_s + rem_a_s) begin
                st_nxt_s  = ST_DONE;
                win_nxt_s = WIN_B;
            end else if ((ka_nxt_s == n_r) && (kb_nxt_s == n_r)) begin
                st_nxt_s  = ST_SUDDEN;
                rnd_nxt_s = {SCORE_W{1'b0}};
            end else begin
                st_nxt_s  = ST_REG;
            end
        end else if ((state_r == ST_SUDDEN) && turn) begin
            if (a_x_s > b_x_s) begin
                st_nxt_s  = ST_DONE;
                win_nxt_s = WIN_A;
            end else if (b_x_s > a_x_s) begin
                st_nxt_s  = ST_DONE;
                win_nxt_s = WIN_B;
            end else if (rnd_inc_s >= SD_LIM) begin
                st_nxt_s  = ST_DONE;
                win_nxt_s = WIN_DRAW;
            end else begin
                st_nxt_s  = ST_SUDDEN;
            end
        end else begin
            st_nxt_s  = state_r;
        end
    end

    // Referee FSM; DONE keeps every output (including sudden) frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            n_r     <= {SCORE_W{1'b0}};
            turn    <= 1'b0;
            rnd     <= {SCORE_W{1'b0}};
            sudden  <= 1'b0;
            done    <= 1'b0;
            winner  <= WIN_NONE;
        end else if (new_game) begin
            state_r <= ST_IDLE;
            n_r     <= {SCORE_W{1'b0}};
            turn    <= 1'b0;
            rnd     <= {SCORE_W{1'b0}};
            sudden  <= 1'b0;
            done    <= 1'b0;
            winner  <= WIN_NONE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en3p ^ en5p) begin
                        n_r     <= en3p ? N3_W : N5_W;
                        state_r <= ST_REG;
                    end
                end
                ST_REG, ST_SUDDEN: begin
                    if (accept_s) begin
                        turn    <= ~turn;
                        rnd     <= rnd_nxt_s;
                        state_r <= st_nxt_s;
                        winner  <= win_nxt_s;
                        done    <= (st_nxt_s == ST_DONE);
                        if (st_nxt_s == ST_SUDDEN) begin
                            sudden <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= state_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_penalty_scoreboard.sv
// Self-checking bench for penalty_scoreboard: vector table plus scripted
// sudden-death, cap and clear sequences, checked through an expectation queue.
module tb_penalty_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en3p = 1'b0, en5p = 1'b0, kick = 1'b0, goal = 1'b0, new_game = 1'b0;
    logic       turn, sudden, done;
    logic [3:0] score_a, score_b, rnd;
    logic [1:0] winner;

    penalty_scoreboard #(.SCORE_W(4), .SD_MAX(2)) dut (
        .clk(clk), .rst(rst), .en3p(en3p), .en5p(en5p), .kick(kick), .goal(goal),
        .new_game(new_game), .turn(turn), .score_a(score_a), .score_b(score_b),
        .rnd(rnd), .sudden(sudden), .done(done), .winner(winner)
    );

    always #5 clk = ~clk;

    // stim = {en3p, en5p, kick, goal, new_game}
    // exp  = {turn, score_a, score_b, rnd, sudden, done, winner}
    typedef struct {
        logic [4:0]  stim;
        logic [16:0] exp;
    } vec_t;

    vec_t        tbl[$];
    logic [16:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic vec_t mk(bit e3, bit e5, bit k, bit g, bit ng,
                                bit t, int sa, int sb, int r, bit sd, bit dn, bit [1:0] w);
        vec_t v;
        v.stim = {e3, e5, k, g, ng};
        v.exp  = {t, 4'(sa), 4'(sb), 4'(r), sd, dn, w};
        return v;
    endfunction

    task automatic check(input int id);
        logic [16:0] act;
        logic [16:0] e;
        act = {turn, score_a, score_b, rnd, sudden, done, winner};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL step%0d: no expectation queued, actual=%h", id, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                n_bad++;
                $display("FAIL step%0d: actual t=%b a=%0d b=%0d rnd=%0d sd=%b dn=%b w=%b required t=%b a=%0d b=%0d rnd=%0d sd=%b dn=%b w=%b",
                         id, act[16], act[15:12], act[11:8], act[7:4], act[3], act[2], act[1:0],
                         e[16], e[15:12], e[11:8], e[7:4], e[3], e[2], e[1:0]);
            end
        end
    endtask

    task automatic apply(input vec_t v, input int id);
        {en3p, en5p, kick, goal, new_game} = v.stim;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        check(id);
    endtask

    initial begin
        // 3-mode early win for A, then a kick while done is ignored
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(0,0,1,1,0, 1,1,0,0,0,0,2'b00));
        tbl.push_back(mk(0,0,1,0,0, 0,1,0,1,0,0,2'b00));
        tbl.push_back(mk(0,0,1,1,0, 1,2,0,1,0,0,2'b00));
        tbl.push_back(mk(0,0,1,0,0, 0,2,0,2,0,1,2'b01));
        tbl.push_back(mk(0,0,1,1,0, 0,2,0,2,0,1,2'b01));
        tbl.push_back(mk(0,0,0,0,0, 0,2,0,2,0,1,2'b01));
        // 5-mode early win for B after six kicks
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(0,1,0,0,0, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(0,0,1,0,0, 1,0,0,0,0,0,2'b00));
        tbl.push_back(mk(0,0,1,1,0, 0,0,1,1,0,0,2'b00));
        tbl.push_back(mk(0,0,1,0,0, 1,0,1,1,0,0,2'b00));
        tbl.push_back(mk(0,0,1,1,0, 0,0,2,2,0,0,2'b00));
        tbl.push_back(mk(0,0,1,0,0, 1,0,2,2,0,0,2'b00));
        tbl.push_back(mk(0,0,1,1,0, 0,0,3,3,0,1,2'b10));
        // both modes high stays idle; kick during IDLE->REG ignored; en3p mid-game ignored (N stays 5)
        tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(0,1,1,1,0, 0,0,0,0,0,0,2'b00));
        tbl.push_back(mk(1,0,1,1,0, 1,1,0,0,0,0,2'b00));
        tbl.push_back(mk(1,0,1,0,0, 0,1,0,1,0,0,2'b00));
        tbl.push_back(mk(1,0,1,1,0, 1,2,0,1,0,0,2'b00));
        tbl.push_back(mk(1,0,1,0,0, 0,2,0,2,0,0,2'b00));

        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(17'd0);
        check(0);
        rst = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i + 1);
        end

        // 5-mode: 5-5 after regulation, then sudden-death win for A
        apply(mk(0,0,0,0,1, 0,0,0,0,0,0,2'b00), 100);
        apply(mk(0,1,0,0,0, 0,0,0,0,0,0,2'b00), 101);
        for (int i = 1; i <= 10; i++) begin
            if (i % 2 == 1)
                apply(mk(0,0,1,1,0, 1,(i+1)/2,(i-1)/2,(i-1)/2,0,0,2'b00), 101 + i);
            else if (i == 10)
                apply(mk(0,0,1,1,0, 0,5,5,0,1,0,2'b00), 101 + i);
            else
                apply(mk(0,0,1,1,0, 0,i/2,i/2,i/2,0,0,2'b00), 101 + i);
        end
        apply(mk(0,0,1,1,0, 1,6,5,0,1,0,2'b00), 112);
        apply(mk(0,0,1,0,0, 0,6,5,1,1,1,2'b01), 113);

        // 3-mode all misses: sudden death hits the cap of two rounds -> draw
        apply(mk(0,0,0,0,1, 0,0,0,0,0,0,2'b00), 200);
        apply(mk(1,0,0,0,0, 0,0,0,0,0,0,2'b00), 201);
        for (int i = 1; i <= 6; i++) begin
            if (i % 2 == 1)
                apply(mk(0,0,1,0,0, 1,0,0,(i-1)/2,0,0,2'b00), 201 + i);
            else if (i == 6)
                apply(mk(0,0,1,0,0, 0,0,0,0,1,0,2'b00), 201 + i);
            else
                apply(mk(0,0,1,0,0, 0,0,0,i/2,0,0,2'b00), 201 + i);
        end
        apply(mk(0,0,1,0,0, 1,0,0,0,1,0,2'b00), 208);
        apply(mk(0,0,1,0,0, 0,0,0,1,1,0,2'b00), 209);
        apply(mk(0,0,1,0,0, 1,0,0,1,1,0,2'b00), 210);
        apply(mk(0,0,1,0,0, 0,0,0,2,1,1,2'b11), 211);

        // async reset at 1-1, then new_game colliding with a kick
        apply(mk(0,0,0,0,1, 0,0,0,0,0,0,2'b00), 300);
        apply(mk(1,0,0,0,0, 0,0,0,0,0,0,2'b00), 301);
        apply(mk(0,0,1,1,0, 1,1,0,0,0,0,2'b00), 302);
        apply(mk(0,0,1,1,0, 0,1,1,1,0,0,2'b00), 303);
        kick = 1'b0;
        rst  = 1'b0;
        #2;
        exp_q.push_back(17'd0);
        check(304);
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(mk(0,0,1,1,0, 0,0,0,0,0,0,2'b00), 305);
        apply(mk(1,0,0,0,0, 0,0,0,0,0,0,2'b00), 306);
        apply(mk(0,0,1,1,0, 1,1,0,0,0,0,2'b00), 307);
        apply(mk(0,0,1,1,1, 0,0,0,0,0,0,2'b00), 308);
        apply(mk(0,0,1,1,0, 0,0,0,0,0,0,2'b00), 309);
        {en3p, en5p, kick, goal, new_game} = 5'b00000;

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: actual=%0d queued expectations required=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
